decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV32I decode stage; successor of the single-format combinational decoder.
//  Decodes all base formats (R/I/S/B/U/J): register indices, funct fields,
//  sign-extended immediate, opcode class and legality.
//  Decoded words go into a DEPTH-entry FIFO with valid/ready on both sides,
//  between fetch and register-read/ALU. Supports flush and back-pressure.
// PARAMETERS
//  XLEN   32  immediate output width; sign-extend from bit 31 of imm
//  DEPTH  2   decoded-entry FIFO depth; power of 2, >=2
// PORTS
//  clk         in   1     rising-edge clock
//  rst         in   1     synchronous, active-high reset
//  flush       in   1     drop all queued entries (e.g. taken branch)
//  in_valid    in   1     in_instr is valid
//  in_ready    out  1     FIFO can accept; = !full (no same-cycle pop credit)
//  in_instr    in   32    raw instruction
//  out_valid   out  1     FIFO head valid; = !empty
//  out_ready   in   1     consumer takes head this cycle
//  out_rs1     out  5     instr[19:15]; 0 for U/J/illegal
//  out_rs2     out  5     instr[24:20]; 0 unless S/B/R
//  out_rd      out  5     instr[11:7]; 0 for S/B/illegal
//  out_rd_we   out  1     writes rd; forced 0 when rd==0
//  out_funct3  out  3     instr[14:12]; 0 for U/J/illegal
//  out_alt     out  1     instr[30] for R-type and OP-IMM shift-right; else 0
//  out_imm     out  XLEN  sign-extended immediate per format; 0 for R/illegal
//  out_class   out  4     0 LOAD,1 OPIMM,2 STORE,3 OP,4 BRANCH,5 LUI,6 AUIPC,
//                         7 JAL,8 JALR,9 FENCE,10 SYSTEM,15 ILLEGAL
//  out_illegal out  1     instruction illegal (entry still delivered)
//  out_mext    out  1     M-extension op (0 when DECODE_MEXT_EN undefined)
// BEHAVIOUR
//  - Reset: FIFO empty, wr/rd pointers 0, in_ready=1, out_valid=0; all out_*
//    data fields 0 while empty (masked, not stale).
//  - Decode is combinational on in_instr; push when in_valid&&in_ready.
//  - Latency: accepted in cycle N -> out_valid in N+1 (empty FIFO case).
//  - Pop when out_valid&&out_ready; head advances next edge.
//  - Push+pop same cycle: both occur, count unchanged. When full, no push even
//    if popping (in_ready=0 that cycle).
//  - Pointers wrap modulo DEPTH; count held in log2(DEPTH)+1 bits.
//  - flush: next edge FIFO empty, pointers 0; a push in the same cycle as
//    flush is discarded. flush has priority over push/pop; rst over flush.
//  - Imm formats: I={{20{i31}},i[31:20]}; S={..,i[31:25],i[11:7]};
//    B={..,i[31],i[7],i[30:25],i[11:8],0}; U={i[31:12],12'b0};
//    J={..,i[31],i[19:12],i[20],i[30:21],0}; all sign-extended to XLEN.
//  - Illegal: instr[1:0]!=2'b11; unknown opcode; OP with funct7 not 0000000
//    or 0100000 (0100000 legal only for funct3 000/101); OP-IMM shift with
//    bad funct7; LOAD funct3 in {3,6,7}; STORE funct3>2; BRANCH funct3 2/3;
//    JALR funct3!=0. Illegal -> class 15, rd_we=0, rs/rd/imm/funct3 zeroed.
//  - addi x0,x0,0 decodes as OPIMM, rd_we=0 (canonical NOP).
// CONFIGURATION
//  DECODE_MEXT_EN defined: OP with funct7=0000001 legal, class 3, out_mext=1,
//   out_alt=0. Undefined: that encoding illegal, out_mext tied 0.
// TESTING
//  - rst 1 cycle, then idle -> in_ready=1, out_valid=0, out_imm=0.
//  - push 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle class 1,
//    rd=1, rd_we=1, imm=0xFFFFFFFF, illegal=0.
//  - push 0xFE209EE3 (bne x1,x2,-4) -> class 4, rs1=1, rs2=2, rd_we=0,
//    imm=0xFFFFFFFC.
//  - out_ready=0, push DEPTH entries -> in_ready=0 after DEPTH pushes; next
//    push ignored; release -> entries pop in order, in_ready=1 again.
//  - full FIFO + flush with in_valid=1 -> next cycle out_valid=0,
//    in_ready=1, flushed-cycle instruction absent.
//  - push 0x022081B3 (mul x3,x1,x2) -> with DECODE_MEXT_EN: class 3,
//    mext=1, illegal=0; without: class 15, illegal=1, rd_we=0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of all base formats into a small
// decoded-entry FIFO with valid/ready handshakes, flush and back-pressure.
// Optional feature macro: DECODE_MEXT_EN (accept M-extension OP encodings).
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic [2:0]      out_funct3,
    output logic            out_alt,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_class,
    output logic            out_illegal,
    output logic            out_mext
);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = XLEN + 26;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // ------------------------------------------------------------ decode
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    logic        use_rs1, use_rs2, use_rd, use_f3;
    logic        dec_illegal, dec_alt, dec_mext, dec_rd_we;
    logic [3:0]  dec_class;
    logic [31:0] imm32;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [2:0]  dec_funct3;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        use_rd      = 1'b0;
        use_f3      = 1'b0;
        dec_illegal = 1'b1;
        dec_alt     = 1'b0;
        dec_mext    = 1'b0;
        dec_class   = 4'd15;
        imm32       = 32'd0;
        if (in_instr[1:0] == 2'b11) begin
            case (opcode)
                OPC_LOAD: if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) begin
                    dec_illegal = 1'b0; dec_class = 4'd0; imm32 = imm_i;
                    use_rs1 = 1'b1; use_rd = 1'b1; use_f3 = 1'b1;
                end
                OPC_OPIMM: if ((f3 == 3'b001) ? (f7 == F7_BASE) :
                               (f3 == 3'b101) ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1) begin
                    dec_illegal = 1'b0; dec_class = 4'd1; imm32 = imm_i;
                    use_rs1 = 1'b1; use_rd = 1'b1; use_f3 = 1'b1;
                    dec_alt = (f3 == 3'b101) ? in_instr[30] : 1'b0;
                end
                OPC_STORE: if (f3 <= 3'd2) begin
                    dec_illegal = 1'b0; dec_class = 4'd2; imm32 = imm_s;
                    use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
                end
                OPC_OP: begin
                    if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))) begin
                        dec_illegal = 1'b0; dec_class = 4'd3; dec_alt = in_instr[30];
                        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; use_f3 = 1'b1;
                    end
`ifdef DECODE_MEXT_EN
                    else if (f7 == F7_MEXT) begin
                        dec_illegal = 1'b0; dec_class = 4'd3; dec_mext = 1'b1;
                        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; use_f3 = 1'b1;
                    end
`else
                    else if (f7 == F7_MEXT) begin
                        dec_illegal = 1'b1;
                    end
`endif
                end
                OPC_BRANCH: if (f3 != 3'd2 && f3 != 3'd3) begin
                    dec_illegal = 1'b0; dec_class = 4'd4; imm32 = imm_b;
                    use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
                end
                OPC_LUI: begin
                    dec_illegal = 1'b0; dec_class = 4'd5; imm32 = imm_u; use_rd = 1'b1;
                end
                OPC_AUIPC: begin
                    dec_illegal = 1'b0; dec_class = 4'd6; imm32 = imm_u; use_rd = 1'b1;
                end
                OPC_JAL: begin
                    dec_illegal = 1'b0; dec_class = 4'd7; imm32 = imm_j; use_rd = 1'b1;
                end
                OPC_JALR: if (f3 == 3'd0) begin
                    dec_illegal = 1'b0; dec_class = 4'd8; imm32 = imm_i;
                    use_rs1 = 1'b1; use_rd = 1'b1; use_f3 = 1'b1;
                end
                OPC_FENCE: begin
                    dec_illegal = 1'b0; dec_class = 4'd9; imm32 = imm_i;
                    use_rs1 = 1'b1; use_rd = 1'b1; use_f3 = 1'b1;
                end
                OPC_SYSTEM: begin
                    dec_illegal = 1'b0; dec_class = 4'd10; imm32 = imm_i;
                    use_rs1 = 1'b1; use_rd = 1'b1; use_f3 = 1'b1;
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    assign dec_rs1    = use_rs1 ? in_instr[19:15] : 5'd0;
    assign dec_rs2    = use_rs2 ? in_instr[24:20] : 5'd0;
    assign dec_rd     = use_rd  ? in_instr[11:7]  : 5'd0;
    assign dec_funct3 = use_f3  ? f3 : 3'd0;
    assign dec_rd_we  = (dec_rd != 5'd0);

    generate
        if (XLEN > 32) begin : g_imm_ext
            assign dec_imm = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_imm_eq
            assign dec_imm = imm32[XLEN-1:0];
        end
    endgenerate

    logic [ENTRY_W-1:0] dec_entry;
    assign dec_entry = {dec_mext, dec_illegal, dec_class, dec_imm, dec_alt,
                        dec_funct3, dec_rd_we, dec_rd, dec_rs2, dec_rs1};

    // ------------------------------------------------------------ FIFO
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop, empty;

    assign empty     = (count_q == '0);
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = !empty;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec_entry;
    end

    // Head is masked to zero while empty so consumers never see stale data.
    logic [ENTRY_W-1:0] head, head_masked;
    assign head = mem_q[rd_ptr_q];

    generate
        for (genvar gi = 0; gi < ENTRY_W; gi++) begin : g_mask
            assign head_masked[gi] = head[gi] & !empty;
        end
    endgenerate

    assign {out_mext, out_illegal, out_class, out_imm, out_alt,
            out_funct3, out_rd_we, out_rd, out_rs2, out_rs1} = head_masked;
endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (default XLEN=32, DEPTH=2).
module tb_decode_stage;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]     in_instr;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic            out_rd_we, out_alt, out_illegal, out_mext;
    logic [2:0]      out_funct3;
    logic [XLEN-1:0] out_imm;
    logic [3:0]      out_class;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_funct3(out_funct3), .out_alt(out_alt),
        .out_imm(out_imm), .out_class(out_class), .out_illegal(out_illegal),
        .out_mext(out_mext)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    // Push one instruction into an empty FIFO, check the decoded head, then pop it.
    task automatic dec_check(input string tag, input logic [31:0] instr,
                             input logic [3:0] cls, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd,
                             input logic rd_we, input logic [2:0] f3,
                             input logic alt, input logic [31:0] imm,
                             input logic ill);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = instr;
        step();
        in_valid  = 1'b0;
        check({tag, ".valid"},   out_valid,   1);
        check({tag, ".class"},   out_class,   cls);
        check({tag, ".rs1"},     out_rs1,     rs1);
        check({tag, ".rs2"},     out_rs2,     rs2);
        check({tag, ".rd"},      out_rd,      rd);
        check({tag, ".rd_we"},   out_rd_we,   rd_we);
        check({tag, ".funct3"},  out_funct3,  f3);
        check({tag, ".alt"},     out_alt,     alt);
        check({tag, ".imm"},     out_imm,     imm);
        check({tag, ".illegal"}, out_illegal, ill);
        $display("txn %s instr=0x%08h class=%0d imm=0x%08h", tag, instr, out_class, out_imm);
        step();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'd0;
        step();
        rst = 1'b0;
        step();
        check("rst.in_ready",  in_ready,  1);
        check("rst.out_valid", out_valid, 0);
        check("rst.out_imm",   out_imm,   0);
        check("rst.out_class", out_class, 0);
        $display("txn reset in_ready=%0b out_valid=%0b", in_ready, out_valid);

        // Latency: nothing visible before the accepting edge
        in_valid = 1'b1; in_instr = 32'hFFF00093; out_ready = 1'b1;
        #1;
        check("lat.pre_valid", out_valid, 0);
        in_valid = 1'b0;

        dec_check("addi", 32'hFFF00093, 4'd1, 5'd0, 5'd0, 5'd1, 1'b1, 3'd0, 1'b0, 32'hFFFFFFFF, 1'b0);
        check("addi.popped", out_valid, 0);
        dec_check("bne",  32'hFE209EE3, 4'd4, 5'd1, 5'd2, 5'd0, 1'b0, 3'd1, 1'b0, 32'hFFFFFFFC, 1'b0);
        dec_check("nop",  32'h00000013, 4'd1, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0);
        dec_check("sub",  32'h407302B3, 4'd3, 5'd6, 5'd7, 5'd5, 1'b1, 3'd0, 1'b1, 32'h0,        1'b0);
        dec_check("badop",32'h407312B3, 4'd15,5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 32'h0,        1'b1);
        dec_check("lui",  32'h123450B7, 4'd5, 5'd0, 5'd0, 5'd1, 1'b1, 3'd0, 1'b0, 32'h12345000, 1'b0);
        dec_check("sw",   32'h0020A423, 4'd2, 5'd1, 5'd2, 5'd0, 1'b0, 3'd2, 1'b0, 32'h8,        1'b0);
        dec_check("jal",  32'h0100006F, 4'd7, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 32'h10,       1'b0);
        dec_check("zero", 32'h00000000, 4'd15,5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 32'h0,        1'b1);
        dec_check("srai", 32'h4030D093, 4'd1, 5'd1, 5'd0, 5'd1, 1'b1, 3'd5, 1'b1, 32'h403,      1'b0);
`ifdef DECODE_MEXT_EN
        dec_check("mul",  32'h022081B3, 4'd3, 5'd1, 5'd2, 5'd3, 1'b1, 3'd0, 1'b0, 32'h0,        1'b0);
        check("mul.mext_pre", out_valid, 0);
`else
        dec_check("mul",  32'h022081B3, 4'd15,5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 32'h0,        1'b1);
`endif

        // Fill with back-pressure, then overflow attempt
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check("fill.in_ready", in_ready, 1);
            in_valid = 1'b1; in_instr = addi(5'(i + 1), 12'(i + 10));
            step();
        end
        check("full.in_ready",  in_ready,  0);
        check("full.out_valid", out_valid, 1);
        in_instr = addi(5'd20, 12'd99);
        step();
        in_valid = 1'b0;
        check("full.head_rd", out_rd, 1);
        $display("txn full in_ready=%0b head_rd=%0d", in_ready, out_rd);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain.valid", out_valid, 1);
            check("drain.rd",    out_rd,    5'(i + 1));
            check("drain.imm",   out_imm,   32'(i + 10));
            $display("txn drain rd=%0d imm=%0d", out_rd, out_imm);
            step();
        end
        check("drain.empty",    out_valid, 0);
        check("drain.in_ready", in_ready,  1);

        // Simultaneous push and pop keeps occupancy
        in_valid = 1'b1; in_instr = addi(5'd3, 12'd3); out_ready = 1'b0;
        step();
        in_instr = addi(5'd4, 12'd4); out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("pushpop.rd", out_rd, 4);
        check("pushpop.in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        check("pushpop.empty", out_valid, 0);
        $display("txn pushpop done");

        // Flush a full FIFO with a concurrent push
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_instr = addi(5'(i + 5), 12'(i));
            step();
        end
        in_instr = addi(5'd25, 12'd25); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush.out_valid", out_valid, 0);
        check("flush.in_ready",  in_ready,  1);
        check("flush.out_rd",    out_rd,    0);
        $display("txn flush_full out_valid=%0b", out_valid);

        // Flush a partly filled FIFO: concurrent push must be discarded
        in_valid = 1'b1; in_instr = addi(5'd7, 12'd7);
        step();
        in_instr = addi(5'd8, 12'd8); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush2.out_valid", out_valid, 0);
        dec_check("postflush", addi(5'd9, 12'd9), 4'd1, 5'd0, 5'd0, 5'd9, 1'b1, 3'd0, 1'b0, 32'h9, 1'b0);
        check("postflush.empty", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
